mc_main_fsm: RTL and testbench
==============================

// Module: mc_main_fsm
// PURPOSE
//  Moore main-control FSM for the multicycle MIPS datapath. It sequences a shared ALU, a single
//  unified instruction/data memory and the register file over 3-5 cycles per instruction.
//  It drives the same alu_op encoding that alu_ctrl consumes and pairs with alu_ctrl in mc_controller.
//  Supported: lw, sw, R-type, beq, addi, j. Other opcodes raise illegal_op and refetch.
// PARAMETERS
//  OPW    6  opcode field width
//  STW    4  state register width (12 states used)
// PORTS
//  clk          in   1    system clock, all state updates on rising edge
//  rst_n        in   1    asynchronous active-low reset
//  op           in   OPW  opcode from the instruction register (valid from DECODE onward)
//  zero         in   1    ALU zero flag (used in BRANCH)
//  mem_ready    in   1    memory access complete (honoured only with MC_MEM_WAIT_EN)
//  pc_write     out  1    unconditional PC load
//  branch       out  1    PC load if zero (pc_en = pc_write | branch&zero, formed outside)
//  iord         out  1    0: address=PC, 1: address=ALUOut
//  mem_write    out  1    memory write strobe
//  ir_write     out  1    instruction register load
//  mem_to_reg   out  1    1: write-back data from MDR
//  reg_dst      out  1    1: rd, 0: rt
//  reg_write    out  1    register file write enable
//  alu_srcA     out  1    0: PC, 1: register A
//  alu_srcB     out  2    00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  alu_op       out  2    00 add, 01 sub, 10 use funct (to alu_ctrl)
//  pc_src       out  2    00 ALU result, 01 ALUOut, 10 jump target
//  instr_done   out  1    one-cycle pulse in the final state of each instruction
//  illegal_op   out  1    one-cycle pulse in DECODE on an unsupported opcode
//  state        out  STW  current state (debug)
// BEHAVIOUR
//  - Reset: state=FETCH asynchronously. While rst_n=0, every write strobe (pc_write, ir_write,
//    mem_write, reg_write, branch) and every pulse output is 0. Other outputs take the FETCH decode.
//  - States and transitions (opcode hex):
//    FETCH   iord=0 srcA=0 srcB=01 alu_op=00 pc_src=00 ir_write pc_write  -> DECODE
//    DECODE  srcA=0 srcB=11 alu_op=00; op: 23/2B->MEMADR, 00->EXEC, 04->BRANCH, 08->ADDIEX,
//            02->JUMP, other->FETCH with illegal_op
//    MEMADR  srcA=1 srcB=10 alu_op=00; 23->MEMRD, 2B->MEMWR
//    MEMRD   iord=1 -> MEMWB
//    MEMWB   reg_dst=0 mem_to_reg=1 reg_write instr_done -> FETCH
//    MEMWR   iord=1 mem_write instr_done -> FETCH
//    EXEC    srcA=1 srcB=00 alu_op=10 -> ALUWB
//    ALUWB   reg_dst=1 mem_to_reg=0 reg_write instr_done -> FETCH
//    BRANCH  srcA=1 srcB=00 alu_op=01 pc_src=01 branch instr_done -> FETCH
//    ADDIEX  srcA=1 srcB=10 alu_op=00 -> ADDIWB
//    ADDIWB  reg_dst=0 mem_to_reg=0 reg_write instr_done -> FETCH
//    JUMP    pc_src=10 pc_write instr_done -> FETCH
//  - Unlisted outputs are 0 in each state. Outputs are a pure function of state (Moore), no op/zero feed-through.
//  - Cycle counts: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
//  - An unencoded state value goes to FETCH on the next edge, with all strobes 0 meanwhile.
//  - Reset mid-instruction: the instruction is abandoned. No write strobe fires after rst_n falls.
// CONFIGURATION
//  MC_MEM_WAIT_EN defined:
//  - FETCH, MEMRD and MEMWR hold while mem_ready=0.
//  - FETCH asserts ir_write/pc_write only in its mem_ready=1 cycle.
//  - MEMWR holds mem_write for the whole wait; instr_done fires in its mem_ready=1 cycle.
//  - MEMRD advances to MEMWB only on mem_ready=1.
//  MC_MEM_WAIT_EN undefined:
//  - mem_ready is ignored (treated as 1); the timing above is fixed.
// TESTING
//  1 lw (op=23), no wait -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 only in cycle 5; instr_done in cycle 5
//  2 R-type (op=00) then addi (op=08) -> alu_op=10 in EXEC, reg_dst=1 in ALUWB, reg_dst=0 in ADDIWB; 4 cycles each
//  3 beq (op=04) with zero=1, then zero=0 -> branch=1, pc_src=01 in cycle 3; FETCH follows; pc_write=0 in BRANCH
//  4 op=3F -> illegal_op pulse in DECODE, back to FETCH next cycle, no reg_write/mem_write ever asserted
//  5 [MC_MEM_WAIT_EN] sw with mem_ready low 3 cycles in MEMWR -> mem_write high 4 cycles, single instr_done
//  6 rst_n low during MEMWB of lw -> reg_write drops at once; after release state=FETCH, first edge -> DECODE

Source files
------------

// File: rtl/mc_main_fsm.sv
// Moore main-control FSM for the multicycle MIPS datapath (lw, sw, R, beq, addi, j).
// Ports: clk, rst_n (async low), op, zero, mem_ready in; datapath strobes, selects, pulses, state out.
// Optional MC_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall on mem_ready=0.
module mc_main_fsm #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           branch,
  output logic           iord,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_srcA,
  output logic [1:0]     alu_srcB,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [STW-1:0] state
);

  typedef enum logic [STW-1:0] {
    S_FETCH  = STW'(0),
    S_DECODE = STW'(1),
    S_MEMADR = STW'(2),
    S_MEMRD  = STW'(3),
    S_MEMWB  = STW'(4),
    S_MEMWR  = STW'(5),
    S_EXEC   = STW'(6),
    S_ALUWB  = STW'(7),
    S_BRANCH = STW'(8),
    S_ADDIEX = STW'(9),
    S_ADDIWB = STW'(10),
    S_JUMP   = STW'(11)
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'('h00);
  localparam logic [OPW-1:0] OP_J    = OPW'('h02);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'('h04);
  localparam logic [OPW-1:0] OP_ADDI = OPW'('h08);
  localparam logic [OPW-1:0] OP_LW   = OPW'('h23);
  localparam logic [OPW-1:0] OP_SW   = OPW'('h2B);

  state_t r_state;
  state_t w_next;

  logic       w_rdy;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_done;
  logic       w_ill;

`ifdef MC_MEM_WAIT_EN
  assign w_rdy = mem_ready;
`else
  logic w_unused;
  assign w_unused = mem_ready;
  assign w_rdy = 1'b1;
`endif

  logic w_unused_zero;
  assign w_unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_done      = 1'b0;
    w_ill       = 1'b0;
    iord        = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    alu_srcA    = 1'b0;
    alu_srcB    = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        alu_srcB   = 2'b01;
        w_pc_write = w_rdy;
        w_ir_write = w_rdy;
        if (w_rdy) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_srcB = 2'b11;
        unique case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_ill  = 1'b1;
            w_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        w_next   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (w_rdy) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
        w_done      = w_rdy;
        if (w_rdy) w_next = S_FETCH;
      end
      S_EXEC: begin
        alu_srcA = 1'b1;
        alu_op   = 2'b10;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_srcA = 1'b1;
        alu_op   = 2'b01;
        pc_src   = 2'b01;
        w_branch = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        w_next   = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are masked by rst_n so nothing fires during reset.
  assign pc_write   = w_pc_write  & rst_n;
  assign branch     = w_branch    & rst_n;
  assign mem_write  = w_mem_write & rst_n;
  assign ir_write   = w_ir_write  & rst_n;
  assign reg_write  = w_reg_write & rst_n;
  assign instr_done = w_done      & rst_n;
  assign illegal_op = w_ill       & rst_n;
  assign state      = r_state;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Table-driven bench for mc_main_fsm.
// Covers every instruction path, illegal opcode, mem_ready and mid-instruction reset.
module tb_mc_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, branch, iord, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_srcA;
  logic [1:0] alu_srcB, alu_op, pc_src;
  logic       instr_done, illegal_op;
  logic [3:0] state;
  logic [16:0] ctl;

  int n_vec = 0;
  int n_err = 0;

  mc_main_fsm #(.OPW(6), .STW(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .branch(branch),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_srcA(alu_srcA),
    .alu_srcB(alu_srcB), .alu_op(alu_op), .pc_src(pc_src),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  // {pw,br,iord,mw,irw,m2r,rd,rw,srcA,srcB,aop,psrc,done,ill}
  assign ctl = {pc_write, branch, iord, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_srcA,
                alu_srcB, alu_op, pc_src, instr_done, illegal_op};

  localparam logic [16:0] C_FETCH = 17'b1_0_0_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [16:0] C_DECI  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [16:0] C_MADR  = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] C_MRD   = 17'b0_0_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [16:0] C_MWR   = 17'b0_0_1_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [16:0] C_EXEC  = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [16:0] C_AWB   = 17'b0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [16:0] C_BR    = 17'b0_1_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [16:0] C_AIEX  = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] C_AIWB  = 17'b0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_0_0_0_00_00_10_1_0;

  typedef struct packed {
    logic [5:0]  op;
    logic        zero;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  int mw_cnt;
  int dn_cnt;

  initial begin
    // lw
    tv.push_back('{6'h23, 1'b0, 4'd0, C_FETCH});
    tv.push_back('{6'h23, 1'b0, 4'd1, C_DEC});
    tv.push_back('{6'h23, 1'b0, 4'd2, C_MADR});
    tv.push_back('{6'h23, 1'b0, 4'd3, C_MRD});
    tv.push_back('{6'h23, 1'b0, 4'd4, C_MWB});
    // R-type
    tv.push_back('{6'h00, 1'b0, 4'd0, C_FETCH});
    tv.push_back('{6'h00, 1'b0, 4'd1, C_DEC});
    tv.push_back('{6'h00, 1'b0, 4'd6, C_EXEC});
    tv.push_back('{6'h00, 1'b0, 4'd7, C_AWB});
    // addi
    tv.push_back('{6'h08, 1'b0, 4'd0, C_FETCH});
    tv.push_back('{6'h08, 1'b0, 4'd1, C_DEC});
    tv.push_back('{6'h08, 1'b0, 4'd9, C_AIEX});
    tv.push_back('{6'h08, 1'b0, 4'd10, C_AIWB});
    // beq taken / not taken (outputs are Moore, identical)
    tv.push_back('{6'h04, 1'b1, 4'd0, C_FETCH});
    tv.push_back('{6'h04, 1'b1, 4'd1, C_DEC});
    tv.push_back('{6'h04, 1'b1, 4'd8, C_BR});
    tv.push_back('{6'h04, 1'b0, 4'd0, C_FETCH});
    tv.push_back('{6'h04, 1'b0, 4'd1, C_DEC});
    tv.push_back('{6'h04, 1'b0, 4'd8, C_BR});
    // j
    tv.push_back('{6'h02, 1'b0, 4'd0, C_FETCH});
    tv.push_back('{6'h02, 1'b0, 4'd1, C_DEC});
    tv.push_back('{6'h02, 1'b0, 4'd11, C_JMP});
    // sw
    tv.push_back('{6'h2B, 1'b0, 4'd0, C_FETCH});
    tv.push_back('{6'h2B, 1'b0, 4'd1, C_DEC});
    tv.push_back('{6'h2B, 1'b0, 4'd2, C_MADR});
    tv.push_back('{6'h2B, 1'b0, 4'd5, C_MWR});
    // illegal
    tv.push_back('{6'h3F, 1'b0, 4'd0, C_FETCH});
    tv.push_back('{6'h3F, 1'b0, 4'd1, C_DECI});

    // reset state: strobes masked, FETCH selects visible
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'(17'b0_0_0_0_0_0_0_0_0_01_00_00_0_0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      op   = tv[i].op;
      zero = tv[i].zero;
      #1;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(tv[i].st));
      chk($sformatf("v%0d_ctl", i), 32'(ctl), 32'(tv[i].ctl));
      @(negedge clk);
    end

`ifdef MC_MEM_WAIT_EN
    // sw with memory stalled 3 cycles in MEMWR
    op = 6'h2B;
    mem_ready = 1'b0;
    #1;
    chk("wait_fetch_hold_pw", 32'(pc_write), 32'd0);
    @(negedge clk);
    chk("wait_fetch_hold_st", 32'(state), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("wait_fetch_pw", 32'(pc_write), 32'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("wait_memwr_st", 32'(state), 32'd5);
    mw_cnt = 0;
    dn_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1;
      mw_cnt += int'(mem_write);
      dn_cnt += int'(instr_done);
      @(negedge clk);
    end
    chk("wait_mw_cycles", 32'(mw_cnt), 32'd4);
    chk("wait_done_cnt", 32'(dn_cnt), 32'd1);
    chk("wait_back_fetch", 32'(state), 32'd0);
`else
    // mem_ready ignored: FETCH still loads and advances
    op = 6'h3F;
    mem_ready = 1'b0;
    #1;
    chk("nowait_fetch_pw", 32'(pc_write), 32'd1);
    @(negedge clk);
    chk("nowait_decode", 32'(state), 32'd1);
    @(negedge clk);
    chk("nowait_back_fetch", 32'(state), 32'd0);
    mem_ready = 1'b1;
`endif

    // reset in MEMWB of lw
    op = 6'h23;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_memwb_st", 32'(state), 32'd4);
    chk("mid_memwb_rw", 32'(reg_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rw", 32'(reg_write), 32'd0);
    chk("mid_rst_st", 32'(state), 32'd0);
    chk("mid_rst_pw", 32'(pc_write), 32'd0);
    chk("mid_rst_irw", 32'(ir_write), 32'd0);
    chk("mid_rst_done", 32'(instr_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_hold", 32'(state), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_pw", 32'(pc_write), 32'd1);
    @(negedge clk);
    chk("rel_decode", 32'(state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
